// File: rtl/regfile_param_if.sv
// Register file access bundle: one write port, two read ports, busy.
// The datapath drives the master side; the register file is the slave.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              busy;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: 2 async read ports, 1 sync write port.
// Synchronous reset runs a clear sequencer; busy guards the array.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic clk,
    input  logic rst,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;
    logic              busy_q;
    logic              busy_nx;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic              wr_ok;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // Writes to a hardwired-zero entry 0 are dropped everywhere.
    assign wr_ok = !((ZERO_REG != 0) && (bus.waddr == '0));

    // Sequencer state, clear counter and registered busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy_q <= busy_nx;
        end
    end

    // Next state and array write selection (clear or datapath write).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        busy_nx  = busy_q;
        mem_we   = 1'b0;
        mem_wa   = bus.waddr;
        mem_wd   = bus.wdata;
        unique case (state)
            CLEAR: begin
                mem_we  = !rst;
                mem_wa  = cnt;
                mem_wd  = '0;
                cnt_nx  = cnt + 1'b1;
                busy_nx = 1'b1;
                if (cnt == '1) begin
                    state_nx = READY;
                    busy_nx  = 1'b0;
                end
            end
            READY: begin
                busy_nx = 1'b0;
                mem_we  = !rst && bus.we && wr_ok;
            end
            default: begin
                state_nx = CLEAR;
            end
        endcase
    end

    // Storage array; no reset, the sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Read port 1: busy mask, zero register, then bypass, then array.
    always_comb begin
        rd1 = mem[bus.raddr1];
        if (busy_q || ((ZERO_REG != 0) && (bus.raddr1 == '0))) begin
            rd1 = '0;
        end else if ((BYPASS != 0) && bus.we && wr_ok &&
                     (bus.waddr == bus.raddr1)) begin
            rd1 = bus.wdata;
        end
    end

    // Read port 2: resolved independently of port 1.
    always_comb begin
        rd2 = mem[bus.raddr2];
        if (busy_q || ((ZERO_REG != 0) && (bus.raddr2 == '0))) begin
            rd2 = '0;
        end else if ((BYPASS != 0) && bus.we && wr_ok &&
                     (bus.waddr == bus.raddr2)) begin
            rd2 = bus.wdata;
        end
    end

    assign bus.rdata1 = rd1;
    assign bus.rdata2 = rd2;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: three configurations driven together.
// Expected reads come from an array model of the register contents.
module tb_regfile_param;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) bus2 ();

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int dw [3] = '{32, 32, 16};
    int aw [3] = '{5, 5, 3};
    int zr [3] = '{1, 0, 1};
    int bp [3] = '{1, 0, 1};

    logic [31:0] m [3][32];
    int          pend [3];
    bit          mvalid = 1'b0;

    logic        c_we;
    logic [4:0]  c_wa;
    logic [31:0] c_wd;

    typedef struct {
        int          inst;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb;
        string       tag;
    } exp_t;

    exp_t  q[$];
    string phase = "init";
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic logic [31:0] dmask(int i);
        return 32'hFFFF_FFFF >> (32 - dw[i]);
    endfunction

    function automatic int amask(int i);
        return (1 << aw[i]) - 1;
    endfunction

    function automatic logic [31:0] model_rd(int i, logic [4:0] ra_in);
        int   ra;
        int   wa;
        logic wz;
        ra = int'(ra_in) & amask(i);
        wa = int'(c_wa) & amask(i);
        wz = (zr[i] != 0) && (wa == 0);
        if (pend[i] > 0) return 32'h0;
        if ((zr[i] != 0) && (ra == 0)) return 32'h0;
        if ((bp[i] != 0) && c_we && (wa == ra) && !wz)
            return c_wd & dmask(i);
        return m[i][ra];
    endfunction

    task automatic step(input logic r, input logic w,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        int   wam;
        rst  = r;
        c_we = w;
        c_wa = wa;
        c_wd = wd;
        bus0.we = w; bus0.waddr = wa; bus0.wdata = wd;
        bus0.raddr1 = a1; bus0.raddr2 = a2;
        bus1.we = w; bus1.waddr = wa; bus1.wdata = wd;
        bus1.raddr1 = a1; bus1.raddr2 = a2;
        bus2.we = w; bus2.waddr = wa[2:0]; bus2.wdata = wd[15:0];
        bus2.raddr1 = a1[2:0]; bus2.raddr2 = a2[2:0];
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                e.inst = i;
                e.e1   = model_rd(i, a1);
                e.e2   = model_rd(i, a2);
                e.eb   = pend[i] > 0;
                e.tag  = phase;
                q.push_back(e);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            wam = int'(wa) & amask(i);
            if (r) begin
                pend[i] = 1 << aw[i];
                for (int k = 0; k < 32; k++) m[i][k] = 32'h0;
            end else if (pend[i] > 0) begin
                pend[i]--;
            end else if (w && !((zr[i] != 0) && (wam == 0))) begin
                m[i][wam] = wd & dmask(i);
            end
        end
        if (r) mvalid = 1'b1;
        #1;
    endtask

    task automatic rnd_step(input int rst_pct, input int we_pct);
        logic [4:0]  wa;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        r;
        logic        w;
        wa = 5'($urandom);
        a1 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom);
        a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
        r  = $urandom_range(0, 99) < rst_pct;
        w  = $urandom_range(0, 99) < we_pct;
        step(r, w, wa, $urandom, a1, a2);
    endtask

    task automatic clear_run(input string nm);
        int k;
        int k2;
        k  = 0;
        k2 = -1;
        while (bus0.busy === 1'b1 && k < 100) begin
            rnd_step(0, 70);
            k++;
            if (k2 < 0 && bus2.busy !== 1'b1) k2 = k;
        end
        n_cmp++;
        if (k != 32) begin
            n_bad++;
            $display("FAIL %s busy_len32: got %0d edges, expected 32", nm, k);
        end
        n_cmp++;
        if (k2 != 8) begin
            n_bad++;
            $display("FAIL %s busy_len8: got %0d edges, expected 8", nm, k2);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
        end
    endtask

    logic [31:0] mr1;
    logic [31:0] mr2;
    logic        mb;

    // Monitor: pops expectations and compares against live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.inst)
                    0: begin mr1 = bus0.rdata1; mr2 = bus0.rdata2; mb = bus0.busy; end
                    1: begin mr1 = bus1.rdata1; mr2 = bus1.rdata2; mb = bus1.busy; end
                    default: begin
                        mr1 = {16'h0, bus2.rdata1};
                        mr2 = {16'h0, bus2.rdata2};
                        mb  = bus2.busy;
                    end
                endcase
                n_cmp++;
                if (mr1 !== e.e1 || mr2 !== e.e2 || mb !== e.eb) begin
                    n_bad++;
                    $display("FAIL %s u%0d: got r1=%h r2=%h busy=%b, expected r1=%h r2=%h busy=%b",
                             e.tag, e.inst, mr1, mr2, mb, e.e1, e.e2, e.eb);
                end
            end
        end
    end

    initial begin
        phase = "reset";
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        phase = "clear";
        clear_run("clear");

        phase = "readall";
        read_all();

        phase = "writeback";
        step(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd31, 32'h00000005, 5'd7, 5'd31);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31);

        phase = "zeroreg";
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        phase = "bypass";
        step(1'b0, 1'b1, 5'd9, 32'h00000023, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);

        phase = "w16";
        step(1'b0, 1'b1, 5'd7, 32'h0000FFFF, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);

        phase = "midclear";
        step(1'b1, 1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
        for (int i = 0; i < 10; i++) rnd_step(0, 100);
        step(1'b1, 1'b1, 5'd4, 32'h2, 5'd4, 5'd4);
        clear_run("midclear");
        phase = "readall2";
        read_all();

        phase = "rsterdy";
        step(1'b0, 1'b1, 5'd12, 32'hCAFE0012, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd13, 32'hCAFE0013, 5'd12, 5'd13);
        clear_run("rsterdy");
        read_all();

        phase = "random";
        for (int i = 0; i < 800; i++) rnd_step(1, 50);
        phase = "final";
        for (int i = 0; i < 40; i++) rnd_step(0, 60);
        read_all();

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
